// File: rtl/stencil2d_stream.sv
// Streaming 3x3 stencil over a row-major pixel stream: two line buffers feed a 3x3 window,
// then registered products and a registered sum; any output stall freezes the whole pipeline.
module stencil2d_stream #(
  parameter int DATA_W = 32,
  parameter int COLS   = 64,
  parameter int ROWS   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_we,
  input  logic [3:0]        coef_idx,
  input  logic [DATA_W-1:0] coef_data,
  input  logic              full_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);
  localparam int CW     = $clog2(COLS);
  localparam int RW     = $clog2(ROWS);
  localparam int NDRAIN = 2 * COLS + 2;
  localparam int DW     = $clog2(NDRAIN + 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_TWO    = CW'(2);
  localparam logic [RW-1:0] ROW_TWO    = RW'(2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(NDRAIN - 1);
  localparam logic [DW-1:0] DRAIN_END  = DW'(NDRAIN);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              tail_q, tail_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [DATA_W-1:0] coef_q [9];
  logic [DATA_W-1:0] coef_d [9];
  logic [DATA_W-1:0] win_q  [9];
  logic [DATA_W-1:0] win_d  [9];
  logic [DATA_W-1:0] prod_q [9];
  logic [DATA_W-1:0] prod_d [9];
  logic [DATA_W-1:0] lb0_q  [COLS];
  logic [DATA_W-1:0] lb1_q  [COLS];
  logic              s1_vld_q, s1_vld_d, s1_zero_q, s1_zero_d, s1_last_q, s1_last_d;
  logic              s2_vld_q, s2_vld_d, s2_zero_q, s2_zero_d, s2_last_q, s2_last_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] sum;
  logic              stall, accept, mode_eff, m_ok, last_px, out_done;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall && (state_q != DRAIN) && !tail_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;  mode_d = mode_q;  tail_d = tail_q;
    col_d = col_q;  row_d = row_q;  dcnt_d = dcnt_q;
    coef_d = coef_q;  win_d = win_q;  prod_d = prod_q;
    s1_vld_d = s1_vld_q;  s1_zero_d = s1_zero_q;  s1_last_d = s1_last_q;
    s2_vld_d = s2_vld_q;  s2_zero_d = s2_zero_q;  s2_last_d = s2_last_q;
    out_valid_d = out_valid_q;  out_data_d = out_data_q;  out_last_d = out_last_q;
    sum = '0;
    mode_eff = (state_q == IDLE) ? full_mode : mode_q;
    // Accepting pixel (row,col) completes the window two rows and two columns back.
    m_ok     = (row_q > ROW_TWO) || ((row_q == ROW_TWO) && (col_q >= COL_TWO));
    last_px  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    out_done = out_valid_q && out_ready && out_last_q;

    if (coef_we && state_q == IDLE) begin
      for (int i = 0; i < 9; i++) begin
        if (coef_idx == 4'(i)) coef_d[i] = coef_data;
      end
    end

    if (accept) begin
      col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      if (col_q == COL_LAST) row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      for (int k1 = 0; k1 < 3; k1++) begin
        win_d[k1*3]     = win_q[k1*3+1];
        win_d[k1*3 + 1] = win_q[k1*3+2];
      end
      win_d[2] = lb0_q[col_q];
      win_d[5] = lb1_q[col_q];
      win_d[8] = in_data;
    end

    case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        mode_d  = full_mode;
      end
      RUN: begin
        if (accept && last_px) begin
          if (mode_q) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end else begin
            tail_d = 1'b1;
          end
        end
        if (tail_q && out_done) begin
          state_d = IDLE;
          tail_d  = 1'b0;
        end
      end
      DRAIN: begin
        if (!stall && dcnt_q != DRAIN_END) dcnt_d = dcnt_q + 1'b1;
        if (out_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < 9; i++) sum = sum + prod_q[i];

    if (!stall) begin
      s1_vld_d = 1'b0;  s1_zero_d = 1'b0;  s1_last_d = 1'b0;
      if (accept) begin
        s1_vld_d  = m_ok && (mode_eff || col_q >= COL_TWO);
        s1_zero_d = (col_q < COL_TWO);
        s1_last_d = !mode_eff && last_px;
      end else if (state_q == DRAIN && dcnt_q != DRAIN_END) begin
        s1_vld_d  = 1'b1;
        s1_zero_d = 1'b1;
        s1_last_d = (dcnt_q == DRAIN_LAST);
      end
      for (int i = 0; i < 9; i++) prod_d[i] = coef_q[i] * win_q[i];
      s2_vld_d    = s1_vld_q;  s2_zero_d = s1_zero_q;  s2_last_d = s1_last_q;
      out_valid_d = s2_vld_q;
      out_data_d  = s2_zero_q ? '0 : sum;
      out_last_d  = s2_vld_q && s2_last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;  mode_q <= 1'b0;  tail_q <= 1'b0;
      col_q <= '0;  row_q <= '0;  dcnt_q <= '0;
      for (int i = 0; i < 9; i++) begin
        coef_q[i] <= '0;  win_q[i] <= '0;  prod_q[i] <= '0;
      end
      s1_vld_q <= 1'b0;  s1_zero_q <= 1'b0;  s1_last_q <= 1'b0;
      s2_vld_q <= 1'b0;  s2_zero_q <= 1'b0;  s2_last_q <= 1'b0;
      out_valid_q <= 1'b0;  out_data_q <= '0;  out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;  mode_q <= mode_d;  tail_q <= tail_d;
      col_q <= col_d;  row_q <= row_d;  dcnt_q <= dcnt_d;
      for (int i = 0; i < 9; i++) begin
        coef_q[i] <= coef_d[i];  win_q[i] <= win_d[i];  prod_q[i] <= prod_d[i];
      end
      s1_vld_q <= s1_vld_d;  s1_zero_q <= s1_zero_d;  s1_last_q <= s1_last_d;
      s2_vld_q <= s2_vld_d;  s2_zero_q <= s2_zero_d;  s2_last_q <= s2_last_d;
      out_valid_q <= out_valid_d;  out_data_q <= out_data_d;  out_last_q <= out_last_d;
    end
  end

  // Line buffers are always written before being read within a frame, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= in_data;
    end
  end
endmodule

// File: tb/tb_stencil2d_stream.sv
// Bench for stencil2d_stream at 8x6: reference model pushes expected results as pixels are accepted.
module tb_stencil2d_stream;
  localparam int C = 8;
  localparam int R = 6;
  localparam int N = C * R;

  logic        clk = 1'b0;
  logic        rst;
  logic        coef_we;
  logic [3:0]  coef_idx;
  logic [31:0] coef_data;
  logic        full_mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] img   [N];
  logic [31:0] mcoef [9];
  logic [31:0] exp_dat_q [$];
  bit          exp_last_q[$];

  stencil2d_stream #(.DATA_W(32), .COLS(C), .ROWS(R)) dut (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .full_mode(full_mode), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(int r, int c);
    logic [31:0] acc = 32'd0;
    if (r >= R - 2 || c >= C - 2) return 32'd0;
    for (int k1 = 0; k1 < 3; k1++)
      for (int k2 = 0; k2 < 3; k2++)
        acc = acc + mcoef[k1*3+k2] * img[(r+k1)*C + c + k2];
    return acc;
  endfunction

  function automatic bit push_m(int m, bit fm);
    int rm = m / C;
    int cm = m % C;
    bit interior = (rm < R - 2) && (cm < C - 2);
    if (!(fm || interior)) return 1'b0;
    exp_dat_q.push_back(model(rm, cm));
    exp_last_q.push_back(fm ? (m == N - 1) : (rm == R - 3 && cm == C - 3));
    return 1'b1;
  endfunction

  task automatic write_coef(input int idx, input logic [31:0] val);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_idx = 4'(idx); coef_data = val;
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (idx < 9) mcoef[idx] = val;
  endtask

  task automatic set_all_coef(input logic [31:0] val);
    for (int i = 0; i < 9; i++) write_coef(i, val);
  endtask

  // ordy: 0 always ready, 1 toggling 1,0,..., 2 random. vld: 0 continuous, 1 random gaps.
  task automatic run_frame(input bit fm, input int ordy, input int vld, input int stop_after,
                           input int we_cyc, input int exp_cnt);
    int n = 0, nres = 0, cyc = 0, first_acc = -1, first_out = -1;
    bit done = 1'b0;
    logic [31:0] ed;
    bit el;
    exp_dat_q.delete();
    exp_last_q.delete();
    full_mode = fm;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      in_valid  = (n < N) && (vld == 0 || $urandom_range(3) != 0);
      in_data   = (n < N) ? img[n] : 32'd0;
      out_ready = (ordy == 0) ? 1'b1 : (ordy == 1) ? (cyc % 2 == 0) : ($urandom_range(2) != 0);
      coef_we   = (cyc == we_cyc);
      coef_idx  = 4'd4;
      coef_data = 32'd5;
      @(negedge clk);
      if (out_valid && !out_ready) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready);
        end
      end
      if (in_valid && in_ready) begin
        if (n >= 2*C + 2) begin
          if (push_m(n - 2*C - 2, fm) && first_acc < 0) first_acc = cyc;
        end
        if (n == N - 1 && fm) begin
          for (int m = N - 2*C - 2; m < N; m++) void'(push_m(m, 1'b1));
        end
        n++;
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        vectors++;
        if (exp_dat_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_result got=%h want=none", out_data);
        end else begin
          ed = exp_dat_q.pop_front();
          el = exp_last_q.pop_front();
          if (out_data !== ed) begin
            miscompares++;
            $display("FAIL result_%0d got=%h want=%h", nres, out_data, ed);
          end
          vectors++;
          if (out_last !== el) begin
            miscompares++;
            $display("FAIL last_%0d got=%b want=%b", nres, out_last, el);
          end
        end
        nres++;
        if (out_last) done = 1'b1;
      end
      if (stop_after >= 0 && n >= stop_after) done = 1'b1;
      cyc++;
    end
    coef_we = 1'b0;
    if (stop_after >= 0) return;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL frame_timeout got=%0d results want=%0d", nres, exp_cnt);
    end
    vectors++;
    if (nres != exp_cnt || exp_dat_q.size() != 0) begin
      miscompares++;
      $display("FAIL result_count got=%0d pending=%0d want=%0d", nres, exp_dat_q.size(), exp_cnt);
    end
    if (ordy == 0 && vld == 0) begin
      vectors++;
      if (first_out - first_acc != 3) begin
        miscompares++;
        $display("FAIL latency got=%0d want=3", first_out - first_acc);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_last got=%b want=0", busy);
    end
  endtask

  task automatic check_cleared(input string tag);
    vectors += 5;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_out_valid got=%b want=0", tag, out_valid); end
    if (out_data !== 32'd0) begin miscompares++; $display("FAIL %s_out_data got=%h want=0", tag, out_data); end
    if (out_last !== 1'b0) begin miscompares++; $display("FAIL %s_out_last got=%b want=0", tag, out_last); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy got=%b want=0", tag, busy); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL %s_in_ready got=%b want=1", tag, in_ready); end
  endtask

  task automatic test_reset;
    rst = 1'b1; coef_we = 1'b0; coef_idx = 4'd0; coef_data = 32'd0;
    full_mode = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) mcoef[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_interior_ones;
    set_all_coef(32'd1);
    write_coef(13, 32'd7);
    for (int i = 0; i < N; i++) img[i] = 32'd1;
    run_frame(1'b0, 0, 0, -1, -1, (R-2)*(C-2));
  endtask

  task automatic test_full_center;
    set_all_coef(32'd0);
    write_coef(4, 32'd1);
    for (int i = 0; i < N; i++) img[i] = 32'(i);
    run_frame(1'b1, 0, 0, -1, -1, N);
  endtask

  task automatic test_wrap;
    set_all_coef(32'd0);
    write_coef(0, 32'h8000_0000);
    for (int i = 0; i < N; i++) img[i] = 32'd0;
    img[0] = 32'd2;
    run_frame(1'b0, 0, 0, -1, -1, (R-2)*(C-2));
  endtask

  task automatic test_stall_toggle;
    set_all_coef(32'd1);
    for (int i = 0; i < N; i++) img[i] = 32'd1;
    run_frame(1'b0, 1, 0, -1, -1, (R-2)*(C-2));
  endtask

  task automatic test_reset_mid;
    set_all_coef(32'd1);
    for (int i = 0; i < N; i++) img[i] = 32'd1;
    run_frame(1'b0, 0, 0, 20, -1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_mid_frame got=%b want=1", busy);
    end
    rst = 1'b1;
    #1;
    check_cleared("mid_reset");
    for (int i = 0; i < 9; i++) mcoef[i] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    run_frame(1'b0, 0, 0, -1, -1, (R-2)*(C-2));
    set_all_coef(32'd1);
    run_frame(1'b0, 0, 0, -1, -1, (R-2)*(C-2));
  endtask

  task automatic test_coef_in_run;
    for (int i = 0; i < 9; i++) write_coef(i, 32'(i + 2));
    for (int i = 0; i < N; i++) img[i] = $urandom;
    run_frame(1'b0, 0, 0, -1, 10, (R-2)*(C-2));
  endtask

  task automatic test_random_full;
    for (int i = 0; i < 9; i++) write_coef(i, $urandom);
    for (int i = 0; i < N; i++) img[i] = $urandom;
    run_frame(1'b1, 2, 1, -1, -1, N);
    run_frame(1'b0, 2, 1, -1, -1, (R-2)*(C-2));
  endtask

  initial begin
    test_reset();
    test_interior_ones();
    test_full_center();
    test_wrap();
    test_stall_toggle();
    test_reset_mid();
    test_coef_in_run();
    test_random_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
